// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive controller.
//   rx_state_e : frame FSM state encoding
//   PAR_EVEN / PAR_ODD : encodings of the PAR_TYP input
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } rx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Bundle of the UART receive controller's line, configuration and result signals.
//   master : the side that drives RX_IN and the configuration, and consumes the results
//   slave  : the receive controller itself
//   RX_IN      serial line, idle high, already synchronous to CLK
//   PRESCALE   CLK cycles per bit (8, 16 or 32)
//   PAR_EN     parity bit present; PAR_TYP 0 = even, 1 = odd
//   STOP2      1 = two stop bits
//   P_DATA     received word; Data_Valid one-cycle strobe
//   par_err    one-cycle parity error strobe; stp_err one-cycle stop error strobe
//   busy       high whenever the frame FSM is not idle
interface uart_rx_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int PS_W   = 6
) ();

  logic              RX_IN;
  logic [PS_W-1:0]   PRESCALE;
  logic              PAR_EN;
  logic              PAR_TYP;
  logic              STOP2;
  logic [DATA_W-1:0] P_DATA;
  logic              Data_Valid;
  logic              par_err;
  logic              stp_err;
  logic              busy;

  modport master (
    output RX_IN, PRESCALE, PAR_EN, PAR_TYP, STOP2,
    input  P_DATA, Data_Valid, par_err, stp_err, busy
  );

  modport slave (
    input  RX_IN, PRESCALE, PAR_EN, PAR_TYP, STOP2,
    output P_DATA, Data_Valid, par_err, stp_err, busy
  );

endinterface

// File: rtl/uart_rx_sampler.sv
// Oversampling edge counter and mid-bit sampler.
// The edge counter runs 0..prescale-1 inside each bit while run is high and is
// held at 0 otherwise, so the first cycle of a new frame always sees count 0.
// With H = prescale/2, the line is sampled at counts H-1 and H; at count H+1
// the bit is decided from those two samples plus the live line (majority), or
// from the count-H sample alone when MAJ_VOTE = 0.
//   CLK, RST  clock, asynchronous active-high reset
//   run       frame in progress (counter enable)
//   rx_in     serial line
//   prescale  latched CLK cycles per bit
//   bit_val   decided bit value, meaningful while dec_stb is high
//   dec_stb   decision point of the current bit
//   bnd_stb   last cycle of the current bit (counter wraps on the next edge)
module uart_rx_sampler #(
  parameter int PS_W     = 6,
  parameter bit MAJ_VOTE = 1'b1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            run,
  input  logic            rx_in,
  input  logic [PS_W-1:0] prescale,
  output logic            bit_val,
  output logic            dec_stb,
  output logic            bnd_stb
);

  localparam logic [PS_W-1:0] ONE = PS_W'(1);

  logic [PS_W-1:0] edge_cnt;
  logic [PS_W-1:0] half;
  logic            smp_lo;
  logic            smp_mid;
  logic            maj;

  assign half    = prescale >> 1;
  assign dec_stb = run && (edge_cnt == half + ONE);
  assign bnd_stb = run && (edge_cnt == prescale - ONE);

  // The third vote is the live line at the decision count, so the decision
  // needs no extra cycle of latency.
  assign maj     = (smp_lo & smp_mid) | (smp_lo & rx_in) | (smp_mid & rx_in);
  assign bit_val = MAJ_VOTE ? maj : smp_mid;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples values from before the clock edge regardless of order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      edge_cnt <= '0;
      smp_lo   <= 1'b1;
      smp_mid  <= 1'b1;
    end else if (!run) begin
      edge_cnt <= '0;
    end else begin
      edge_cnt <= bnd_stb ? '0 : edge_cnt + ONE;
      if (edge_cnt == half - ONE) smp_lo  <= rx_in;
      if (edge_cnt == half)       smp_mid <= rx_in;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Parametrised UART receive controller: frame FSM, bit counter, deserializer
// and parity/stop checks around the oversampling sampler.
//   CLK, RST  oversampling clock, asynchronous active-high reset
//   bus       uart_rx_ctrl_if slave: RX_IN and configuration in, P_DATA,
//             Data_Valid, par_err, stp_err and busy out (all registered)
// Configuration is latched when a start bit is first seen, so mid-frame
// changes only affect the next frame. A frame ends at the decision point of
// its last stop bit, which leaves the rest of that bit to catch a
// back-to-back start edge.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int PS_W     = 6,
  parameter bit MAJ_VOTE = 1'b1
) (
  input logic          CLK,
  input logic          RST,
  uart_rx_ctrl_if.slave bus
);

  localparam int BC_W = $clog2(DATA_W);

  rx_state_e         state;
  logic [BC_W-1:0]   bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic [PS_W-1:0]   prescale_q;
  logic              par_en_q;
  logic              par_typ_q;
  logic              stop2_q;
  logic              par_bad;

  logic              run;
  logic              bit_val;
  logic              dec_stb;
  logic              bnd_stb;
  logic              exp_par;
  logic              last_stop;

  // WAIT_IDLE only watches the raw line, so the sampler is parked there.
  assign run       = (state != IDLE) && (state != WAIT_IDLE);
  assign exp_par   = (par_typ_q == PAR_EVEN) ? ^shreg : ~^shreg;
  assign last_stop = !stop2_q || (bit_cnt != '0);

  uart_rx_sampler #(
    .PS_W     (PS_W),
    .MAJ_VOTE (MAJ_VOTE)
  ) u_sampler (
    .CLK      (CLK),
    .RST      (RST),
    .run      (run),
    .rx_in    (bus.RX_IN),
    .prescale (prescale_q),
    .bit_val  (bit_val),
    .dec_stb  (dec_stb),
    .bnd_stb  (bnd_stb)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state          <= IDLE;
      bit_cnt        <= '0;
      shreg          <= '0;
      prescale_q     <= '0;
      par_en_q       <= 1'b0;
      par_typ_q      <= 1'b0;
      stop2_q        <= 1'b0;
      par_bad        <= 1'b0;
      bus.P_DATA     <= '0;
      bus.Data_Valid <= 1'b0;
      bus.par_err    <= 1'b0;
      bus.stp_err    <= 1'b0;
      bus.busy       <= 1'b0;
    end else begin
      // NOTE: strobes default low every cycle, so each one is a single-cycle
      // pulse unless a branch below raises it on this edge.
      bus.Data_Valid <= 1'b0;
      bus.par_err    <= 1'b0;
      bus.stp_err    <= 1'b0;

      case (state)
        IDLE: begin
          if (!bus.RX_IN) begin
            state      <= START;
            bus.busy   <= 1'b1;
            bit_cnt    <= '0;
            par_bad    <= 1'b0;
            prescale_q <= bus.PRESCALE;
            par_en_q   <= bus.PAR_EN;
            par_typ_q  <= bus.PAR_TYP;
            stop2_q    <= bus.STOP2;
          end
        end

        START: begin
          // A start bit that votes high was a glitch: drop it silently.
          if (dec_stb && bit_val) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end else if (bnd_stb) begin
            state   <= DATA;
            bit_cnt <= '0;
          end
        end

        DATA: begin
          if (dec_stb) shreg <= {bit_val, shreg[DATA_W-1:1]};
          if (bnd_stb) begin
            if (bit_cnt == BC_W'(DATA_W - 1)) begin
              bit_cnt <= '0;
              state   <= par_en_q ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + BC_W'(1);
            end
          end
        end

        PARITY: begin
          // A bad parity bit is only remembered; the frame still runs to its stop bits.
          if (dec_stb && (bit_val != exp_par)) par_bad <= 1'b1;
          if (bnd_stb) begin
            state   <= STOP;
            bit_cnt <= '0;
          end
        end

        STOP: begin
          if (dec_stb) begin
            if (!bit_val) begin
              bus.stp_err <= 1'b1;
              state       <= WAIT_IDLE;
            end else if (last_stop) begin
              state    <= IDLE;
              bus.busy <= 1'b0;
              if (par_bad) begin
                bus.par_err <= 1'b1;
              end else begin
                bus.P_DATA     <= shreg;
                bus.Data_Valid <= 1'b1;
              end
            end
          end else if (bnd_stb) begin
            // Only reached after a good first stop bit of a two-stop frame.
            bit_cnt <= bit_cnt + BC_W'(1);
          end
        end

        WAIT_IDLE: begin
          if (bus.RX_IN) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        end

        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: an 8-bit and a 9-bit instance are
// driven one at a time with directed frames. Every frame pushes its expected
// end-of-frame event (kind, P_DATA value, latency) to a scoreboard; each
// strobe seen on a falling clock edge pops and compares the head entry.
module tb_uart_rx_ctrl;
  import uart_rx_pkg::*;

  typedef enum int {EV_DV = 0, EV_PAR = 1, EV_STP = 2, EV_MULTI = 3, EV_NONE = 4} ev_e;

  typedef struct {
    int         sel;
    ev_e        kind;
    logic [8:0] data;
    int         lat;
    int         t0;
  } exp_t;

  logic       clk      = 1'b0;
  logic       rst      = 1'b1;
  logic       rx8      = 1'b1;
  logic       rx9      = 1'b1;
  logic [5:0] prescale = 6'd8;
  logic       par_en   = 1'b0;
  logic       par_typ  = 1'b0;
  logic       stop2    = 1'b0;

  int   cyc     = 0;
  int   n_pass  = 0;
  int   n_fail  = 0;
  int   n_total = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_ctrl_if #(.DATA_W(8), .PS_W(6)) if8 ();
  uart_rx_ctrl_if #(.DATA_W(9), .PS_W(6)) if9 ();

  assign if8.RX_IN    = rx8;
  assign if8.PRESCALE = prescale;
  assign if8.PAR_EN   = par_en;
  assign if8.PAR_TYP  = par_typ;
  assign if8.STOP2    = stop2;
  assign if9.RX_IN    = rx9;
  assign if9.PRESCALE = prescale;
  assign if9.PAR_EN   = par_en;
  assign if9.PAR_TYP  = par_typ;
  assign if9.STOP2    = stop2;

  uart_rx_ctrl #(.DATA_W(8), .PS_W(6), .MAJ_VOTE(1'b1)) dut8 (
    .CLK (clk),
    .RST (rst),
    .bus (if8.slave)
  );

  uart_rx_ctrl #(.DATA_W(9), .PS_W(6), .MAJ_VOTE(1'b1)) dut9 (
    .CLK (clk),
    .RST (rst),
    .bus (if9.slave)
  );

  always @(posedge clk)
    if (!rst)
      assert (prescale inside {6'd8, 6'd16, 6'd32})
      else $error("FAIL prescale_legal: observed %0d required 8/16/32", prescale);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic observe_one(input int sel, input logic dv, input logic pe, input logic se,
                             input logic [8:0] pd);
    ev_e  k;
    exp_t e;
    if (dv || pe || se) begin
      k = EV_MULTI;
      if (dv && !pe && !se) k = EV_DV;
      else if (pe && !dv && !se) k = EV_PAR;
      else if (se && !dv && !pe) k = EV_STP;
      check("strobe_expected", sb.size() != 0, 1'b1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("event_dut", sel, e.sel);
        check("event_kind", k, e.kind);
        check("event_p_data", pd, e.data);
        check("event_latency", cyc - e.t0, e.lat);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    observe_one(0, if8.Data_Valid, if8.par_err, if8.stp_err, {1'b0, if8.P_DATA});
    observe_one(1, if9.Data_Valid, if9.par_err, if9.stp_err, if9.P_DATA);
  endtask

  task automatic settle(input int n);
    repeat (n) tick();
    check("scoreboard_drained", sb.size(), 0);
  endtask

  // Drives one frame on line sel (0 = 8-bit DUT, 1 = 9-bit DUT), starting at a
  // falling edge. Frame shape follows the current par_en/stop2 settings.
  // gb/gk: invert the line for one cycle at bit gb, cycle gk (-1 = none).
  // cb: switch the PRESCALE input to 16 at the start of bit cb (-1 = none).
  task automatic send_frame(input int sel, input logic [8:0] data, input int dw,
                            input logic pbit, input logic [1:0] stops, input int p,
                            input int gb, input int gk, input int cb,
                            input ev_e kind, input logic [8:0] exp_data);
    logic [15:0] bits;
    int          n;
    logic        v;
    exp_t        e;
    bits    = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < dw; i++) bits[1+i] = data[i];
    n = 1 + dw;
    if (par_en) begin
      bits[n] = pbit;
      n++;
    end
    bits[n] = stops[0];
    n++;
    if (stop2) begin
      bits[n] = stops[1];
      n++;
    end
    if (kind != EV_NONE) begin
      e.sel  = sel;
      e.kind = kind;
      e.data = exp_data;
      e.lat  = (n - 1) * p + p / 2 + 2;
      e.t0   = cyc + 1;
      sb.push_back(e);
    end
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < p; k++) begin
        v = bits[i];
        if (i == gb && k == gk) v = ~v;
        if (i == cb && k == 0) prescale = 6'd16;
        if (sel == 1) rx9 = v;
        else rx8 = v;
        tick();
      end
    end
  endtask

  initial begin
    // Reset state of both instances.
    repeat (3) @(negedge clk);
    check("rst_p_data8", if8.P_DATA, 8'h00);
    check("rst_dv8", if8.Data_Valid, 1'b0);
    check("rst_par8", if8.par_err, 1'b0);
    check("rst_stp8", if8.stp_err, 1'b0);
    check("rst_busy8", if8.busy, 1'b0);
    check("rst_p_data9", if9.P_DATA, 9'h000);
    check("rst_busy9", if9.busy, 1'b0);
    rst = 1'b0;
    settle(4);

    // Plain 8N1 frame at PRESCALE 8: latency 9*8+4+2.
    send_frame(0, 9'h0A5, 8, 1'b0, 2'b11, 8, -1, 0, -1, EV_DV, 9'h0A5);
    settle(10);

    // Even parity: wrong parity bit keeps P_DATA, correct one delivers.
    par_en  = 1'b1;
    par_typ = PAR_EVEN;
    send_frame(0, 9'h03C, 8, 1'b1, 2'b11, 8, -1, 0, -1, EV_PAR, 9'h0A5);
    settle(10);
    send_frame(0, 9'h03C, 8, 1'b0, 2'b11, 8, -1, 0, -1, EV_DV, 9'h03C);
    settle(10);

    // PRESCALE 16: one-cycle glitch on the count-H sample of data bit 0.
    par_en   = 1'b0;
    prescale = 6'd16;
    send_frame(0, 9'h055, 8, 1'b0, 2'b11, 16, 1, 9, -1, EV_DV, 9'h055);
    settle(10);

    // Three-cycle low pulse while idle is rejected as a false start.
    rx8 = 1'b0;
    repeat (3) tick();
    rx8 = 1'b1;
    check("glitch_start_busy", if8.busy, 1'b1);
    settle(40);
    check("glitch_back_idle", if8.busy, 1'b0);

    // Two stop bits, second one low: stp_err, then the line is held low.
    prescale = 6'd8;
    stop2    = 1'b1;
    send_frame(0, 9'h042, 8, 1'b0, 2'b01, 8, -1, 0, -1, EV_STP, 9'h055);
    repeat (40) tick();
    check("wait_idle_busy", if8.busy, 1'b1);
    check("scoreboard_after_break", sb.size(), 0);
    rx8 = 1'b1;
    settle(3);
    check("wait_idle_released", if8.busy, 1'b0);
    send_frame(0, 9'h081, 8, 1'b0, 2'b11, 8, -1, 0, -1, EV_DV, 9'h081);
    settle(10);

    // 9-bit instance, odd parity: back-to-back frames, then a mid-frame
    // PRESCALE change that must not disturb the frame in flight.
    stop2   = 1'b0;
    par_en  = 1'b1;
    par_typ = PAR_ODD;
    send_frame(1, 9'h1FF, 9, 1'b0, 2'b11, 8, -1, 0, -1, EV_DV, 9'h1FF);
    send_frame(1, 9'h000, 9, 1'b1, 2'b11, 8, -1, 0, -1, EV_DV, 9'h000);
    settle(10);
    send_frame(1, 9'h12B, 9, 1'b0, 2'b11, 8, -1, 0, 4, EV_DV, 9'h12B);
    prescale = 6'd8;
    settle(10);

    // Reset asserted during data bit 4 of an 8-bit frame, between clock edges.
    par_en = 1'b0;
    rx8    = 1'b0;
    repeat (8) tick();
    rx8 = 1'b1;
    repeat (32) tick();
    rx8 = 1'b0;
    repeat (3) tick();
    check("busy_before_abort", if8.busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("abort_p_data8", if8.P_DATA, 8'h00);
    check("abort_busy8", if8.busy, 1'b0);
    check("abort_dv8", if8.Data_Valid, 1'b0);
    check("abort_par8", if8.par_err, 1'b0);
    check("abort_stp8", if8.stp_err, 1'b0);
    check("abort_p_data9", if9.P_DATA, 9'h000);
    repeat (2) tick();
    rst = 1'b0;
    rx8 = 1'b1;
    settle(5);
    send_frame(0, 9'h00F, 8, 1'b0, 2'b11, 8, -1, 0, -1, EV_DV, 9'h00F);
    settle(10);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Parametrised UART receive controller: one block holding the frame FSM, oversampling edge counter, bit counter, majority-vote sampler, deserializer and parity/stop checkers. It turns the serial RX_IN stream into parallel words with a one-cycle Data_Valid strobe. Data width, oversampling ratio, parity mode and stop-bit count are configurable, so it replaces the fixed 8-bit RX datapath. It sits between the RX pin (already synchronised to CLK) and the RX FIFO / register file.

Parameters:
DATA_W, 8, data bits per frame; legal range 5..9
PS_W, 6, width of the PRESCALE port; legal PRESCALE values are 8, 16 and 32
MAJ_VOTE, 1, 1 = 3-sample majority vote per bit; 0 = single mid-bit sample

Ports:
CLK  in  1  oversampling clock
RST  in  1  reset; asynchronous, active-high
RX_IN  in  1  serial input, idle high, already synchronous to CLK
PRESCALE  in  PS_W  CLK cycles per bit
PAR_EN  in  1  parity bit present
PAR_TYP  in  1  0 = even parity, 1 = odd parity
STOP2  in  1  1 = two stop bits, 0 = one stop bit
P_DATA  out  DATA_W  received word, LSB first on the line
Data_Valid  out  1  one-cycle strobe; P_DATA is valid on this cycle
par_err  out  1  one-cycle strobe at end of frame with a parity error
stp_err  out  1  one-cycle strobe when a stop bit samples 0
busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. While RST is high: state = IDLE, counters = 0, shift register = 0, P_DATA = 0, and Data_Valid, par_err, stp_err and busy are all 0. Asserting RST mid-frame aborts the frame with no strobes.
- Configuration latch: PRESCALE, PAR_EN, PAR_TYP and STOP2 are captured on the IDLE->START transition. Changes to these inputs mid-frame have no effect on the current frame.
- Edge counter: counts 0..PRESCALE-1 within each bit, then wraps to 0 and increments the bit counter. With H = PRESCALE/2, samples are taken at edge counts H-1, H and H+1. The bit decision is made at edge count H+1: majority of the three samples, or the sample at H alone when MAJ_VOTE = 0.
- States:
  - IDLE: RX_IN == 0 -> START, with the edge counter cleared.
  - START: at the decision point, voted 1 = glitch -> IDLE with no strobes; voted 0 -> DATA at the bit boundary.
  - DATA: each decision shifts the voted bit into the shift register MSB and shifts right (LSB first). After DATA_W bits, at the boundary -> PARITY if PAR_EN, else STOP.
  - PARITY: the voted bit is compared with the expected parity (^data for even, ~^data for odd). A mismatch sets an internal error flag; the frame is not aborted. -> STOP at the boundary.
  - STOP: at each stop-bit decision, a voted 0 -> pulse stp_err and go to WAIT_IDLE, with no Data_Valid. With STOP2 = 1, the first stop bit passes through its boundary and the second is checked the same way. On the last stop decision with value 1 -> IDLE immediately at mid-bit, so a back-to-back start bit is caught.
  - WAIT_IDLE: stays until RX_IN == 1, then -> IDLE. This prevents a break or stuck-low line from being read as start bits.
- End-of-frame output, registered on the cycle IDLE is entered from STOP:
  - parity OK: P_DATA <= shift register and Data_Valid = 1 for one cycle.
  - parity bad: par_err = 1 for one cycle; P_DATA and Data_Valid are unchanged.
- P_DATA holds its value between frames.
- Frame timing: latency from the start-bit falling edge to Data_Valid is (1 + DATA_W + PAR_EN + STOP2)·PRESCALE + H + 2 cycles.
- Simultaneous events: a stop error with a bad parity reports stp_err only.
- Illegal PRESCALE (not 8/16/32): behaviour undefined; an assertion in the bench flags it.

Decomposition:
- Package uart_rx_pkg: state encoding enum (IDLE, START, DATA, PARITY, STOP, WAIT_IDLE) and localparams PAR_EVEN = 0, PAR_ODD = 1.
- One natural sub-module, uart_rx_sampler: the edge counter plus the 3-sample majority vote. It outputs the voted bit, a decision strobe and a bit-boundary strobe.
- FSM, bit counter, shift register and checks stay in uart_rx_ctrl.

Test Plan:
- DATA_W=8, PRESCALE=8, no parity, 1 stop; send 0xA5 -> Data_Valid one cycle with P_DATA=0xA5, no error strobes, latency 9·8+4+2=78 cycles.
- PAR_EN=1, PAR_TYP=0; send 0x3C with parity bit 1 (wrong) -> par_err pulse, no Data_Valid, P_DATA keeps its previous value. Then send 0x3C with parity 0 -> Data_Valid, P_DATA=0x3C.
- PRESCALE=16, MAJ_VOTE=1; send 0x55 with a one-cycle low glitch at edge count H on bit 0 -> P_DATA=0x55. Separately, a 3-cycle RX_IN low pulse while IDLE -> return to IDLE, no strobes.
- STOP2=1; second stop bit forced low -> stp_err pulse and FSM in WAIT_IDLE. Hold RX_IN low 40 cycles -> no new frame; release high -> next frame 0x81 received correctly.
- DATA_W=9, PAR_TYP=1; frames 0x1FF and 0x000 sent back-to-back with zero idle -> two Data_Valid strobes. Change PRESCALE mid-frame -> current frame unaffected.
- Assert RST during DATA bit 4 -> all outputs 0 immediately (asynchronous); after release, a new frame 0x0F is received correctly.
